// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr -- N:1 registered channel multiplexer with valid/ready handshakes.
//
// Each of the N producers presents a word together with a valid flag. One
// channel is granted per cycle. In fixed mode, sel picks the channel. In
// round-robin mode, the grant goes to the first valid channel after the last
// one that was granted. The granted word is captured into a single output
// register, and the register also records the index of the source channel.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (one-hot or zero, combinational)
//   out_data   registered selected word
//   out_ch     registered source channel of out_data
//   out_valid  output register holds a word
//   out_ready  consumer takes the word this cycle
//   sel_err    one-cycle pulse after an edge with mode=0 and sel >= N
module mux_nx1_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err
);

    // sel is widened by one bit, so the range check also works when N is a power of two.
    localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

    logic [W-1:0]    chan_data [N];
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            sel_ok;
    logic            load;
    logic            transfer;
    int              idx;

    logic [W-1:0]    out_data_reg;
    logic [SELW-1:0] out_ch_reg;
    logic            out_valid_reg;
    logic [SELW-1:0] last_grant_reg;
    logic            sel_err_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    assign sel_ok = ({1'b0, sel} < N_EXT);

    // Grant selection. Round-robin scans from last_grant+1 upward and wraps at N-1.
    // The scan ends on last_grant itself, so that channel has the lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (!mode) begin
            if (sel_ok && in_valid[sel]) begin
                gnt_any = 1'b1;
                gnt_idx = sel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(last_grant_reg) + k) % N;
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx[SELW-1:0];
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // The output register is free when it is empty or being drained this cycle.
    assign load     = !out_valid_reg || out_ready;
    assign in_ready = rst ? '0 : (gnt & {N{load}});
    assign transfer = gnt_any && load && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
            out_valid_reg  <= 1'b0;
            last_grant_reg <= SELW'(N-1);
            sel_err_reg    <= 1'b0;
        end else begin
            if (transfer) begin
                out_data_reg   <= chan_data[gnt_idx];
                out_ch_reg     <= gnt_idx;
                out_valid_reg  <= 1'b1;
                last_grant_reg <= gnt_idx;
            end else if (out_ready) begin
                // Drain with nothing to replace it: out_data keeps its last value.
                out_valid_reg <= 1'b0;
            end
            sel_err_reg <= !mode && !sel_ok;
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule
